// File: rtl/scope_trigger_controller_if.sv
// Sample/slope stream in, capture-buffer write port and status out.
// master = producer/reader side, slave = trigger controller.
interface scope_trigger_controller_if #(
    parameter int DATA_BITS = 12,
    parameter int ADDR_BITS = 10
);
    logic                 dataReady;
    logic [DATA_BITS-1:0] dataIn;
    logic                 slopeReady;
    logic                 slopeIsPositive;
    logic [DATA_BITS-1:0] triggerLevel;
    logic                 triggerRising;
    logic                 arm;
    logic                 readDone;

    logic                 writeEnable;
    logic [ADDR_BITS-1:0] writeAddress;
    logic [DATA_BITS-1:0] writeData;
    logic [ADDR_BITS-1:0] triggerAddress;
    logic                 triggered;
    logic                 captureDone;
    logic                 busy;

    modport master (
        output dataReady, dataIn, slopeReady, slopeIsPositive,
               triggerLevel, triggerRising, arm, readDone,
        input  writeEnable, writeAddress, writeData, triggerAddress,
               triggered, captureDone, busy
    );

    modport slave (
        input  dataReady, dataIn, slopeReady, slopeIsPositive,
               triggerLevel, triggerRising, arm, readDone,
        output writeEnable, writeAddress, writeData, triggerAddress,
               triggered, captureDone, busy
    );
endinterface

// File: rtl/scope_trigger_controller.sv
// Slope-qualified level trigger that fills a circular capture buffer with a
// fixed pre-trigger / post-trigger window.
module scope_trigger_controller #(
    parameter int DATA_BITS   = 12,
    parameter int ADDR_BITS   = 10,
    parameter int PRE_SAMPLES = 256,
    parameter int HOLDOFF     = 4
) (
    input logic                        clock,
    input logic                        reset,
    scope_trigger_controller_if.slave  bus
);
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int HOLD_BITS = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    localparam logic [ADDR_BITS-1:0] PRE_LAST  = ADDR_BITS'(PRE_SAMPLES - 1);
    localparam logic [ADDR_BITS-1:0] POST_LAST = ADDR_BITS'(DEPTH - PRE_SAMPLES - 2);
    localparam logic [HOLD_BITS-1:0] HOLD_MAX  = HOLD_BITS'(HOLDOFF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_SEARCH,
        ST_POST,
        ST_DONE
    } state_e;

    state_e                       state_q,       state_d;
    logic [ADDR_BITS-1:0]         ptr_q,         ptr_d;
    logic [ADDR_BITS-1:0]         pre_count_q,   pre_count_d;
    logic [HOLD_BITS-1:0]         hold_count_q,  hold_count_d;
    logic [ADDR_BITS-1:0]         post_count_q,  post_count_d;
    logic signed [DATA_BITS-1:0]  prev_sample_q, prev_sample_d;
    logic                         prev_valid_q,  prev_valid_d;
    logic                         write_en_q,    write_en_d;
    logic [ADDR_BITS-1:0]         write_addr_q,  write_addr_d;
    logic [DATA_BITS-1:0]         write_data_q,  write_data_d;
    logic [ADDR_BITS-1:0]         trig_addr_q,   trig_addr_d;
    logic                         trig_pulse_q,  trig_pulse_d;

    logic                         accept;
    logic                         candidate;
    logic                         rising_hit;
    logic                         falling_hit;
    logic                         trigger_hit;
    logic signed [DATA_BITS-1:0]  sample_s;
    logic signed [DATA_BITS-1:0]  level_s;

    // Trigger qualification: all compares signed at full sample width.
    always_comb begin
        sample_s    = $signed(bus.dataIn);
        level_s     = $signed(bus.triggerLevel);
        accept      = bus.dataReady &&
                      (state_q inside {ST_PREFILL, ST_SEARCH, ST_POST});
        rising_hit  = (prev_sample_q < level_s) && (sample_s >= level_s) &&
                      bus.slopeIsPositive;
        falling_hit = (prev_sample_q > level_s) && (sample_s <= level_s) &&
                      !bus.slopeIsPositive;
        candidate   = accept && (state_q == ST_SEARCH) && bus.slopeReady &&
                      prev_valid_q && (hold_count_q == HOLD_MAX);
        trigger_hit = candidate && (bus.triggerRising ? rising_hit : falling_hit);
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        pre_count_d   = pre_count_q;
        hold_count_d  = hold_count_q;
        post_count_d  = post_count_q;
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        write_en_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        trig_addr_d   = trig_addr_q;
        trig_pulse_d  = 1'b0;

        // Every accepted sample is written one cycle later at the current pointer.
        if (accept) begin
            write_en_d    = 1'b1;
            write_addr_d  = ptr_q;
            write_data_d  = bus.dataIn;
            ptr_d         = ptr_q + 1'b1;
            prev_sample_d = sample_s;
            prev_valid_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d      = ST_PREFILL;
                    ptr_d        = '0;
                    pre_count_d  = '0;
                    hold_count_d = '0;
                    prev_valid_d = 1'b0;
                end
            end
            ST_PREFILL: begin
                if (accept) begin
                    pre_count_d = pre_count_q + 1'b1;
                    if (pre_count_q == PRE_LAST) begin
                        state_d = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (accept) begin
                    if (hold_count_q != HOLD_MAX) begin
                        hold_count_d = hold_count_q + 1'b1;
                    end
                    if (trigger_hit) begin
                        trig_addr_d  = ptr_q;
                        trig_pulse_d = 1'b1;
                        post_count_d = '0;
                        state_d      = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    post_count_d = post_count_q + 1'b1;
                    if (post_count_q == POST_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.readDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            pre_count_q   <= '0;
            hold_count_q  <= '0;
            post_count_q  <= '0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            write_en_q    <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            trig_addr_q   <= '0;
            trig_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pre_count_q   <= pre_count_d;
            hold_count_q  <= hold_count_d;
            post_count_q  <= post_count_d;
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            write_en_q    <= write_en_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            trig_addr_q   <= trig_addr_d;
            trig_pulse_q  <= trig_pulse_d;
        end
    end

    assign bus.writeEnable    = write_en_q;
    assign bus.writeAddress   = write_addr_q;
    assign bus.writeData      = write_data_q;
    assign bus.triggerAddress = trig_addr_q;
    assign bus.triggered      = trig_pulse_q;
    assign bus.captureDone    = (state_q == ST_DONE);
    assign bus.busy           = (state_q inside {ST_PREFILL, ST_SEARCH, ST_POST});
endmodule

// File: tb/tb_scope_trigger_controller.sv
// Directed scenarios plus randomized traffic, checked against a sample-history
// model of the capture window.
module tb_scope_trigger_controller;
    localparam int DW   = 12;
    localparam int AW   = 4;
    localparam int D    = 16;
    localparam int PRE  = 4;
    localparam int HOLD = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    scope_trigger_controller_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    scope_trigger_controller #(
        .DATA_BITS  (DW),
        .ADDR_BITS  (AW),
        .PRE_SAMPLES(PRE),
        .HOLDOFF    (HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: history of accepted samples since arm; phase follows from counts.
    bit m_armed    = 1'b0;
    int m_n        = 0;
    int m_trig     = -1;
    int m_taddr    = 0;
    int hist[$];
    bit e_we       = 1'b0;
    bit e_trig     = 1'b0;
    int e_waddr    = 0;
    int e_wdata    = 0;
    bit m_done_prev = 1'b0;
    int mem[D];

    function automatic bit model_done();
        return m_armed && (m_trig >= 0) && (m_n == m_trig + D - PRE);
    endfunction

    task automatic model_edge();
        int s, lvl, p;
        bit hit;
        e_we   = 1'b0;
        e_trig = 1'b0;
        if (reset) begin
            m_armed = 1'b0;
            m_n     = 0;
            m_trig  = -1;
            m_taddr = 0;
            hist.delete();
            return;
        end
        if (!m_armed) begin
            if (bus.arm) begin
                m_armed = 1'b1;
                m_n     = 0;
                m_trig  = -1;
                hist.delete();
            end
        end else if (model_done()) begin
            if (bus.readDone) m_armed = 1'b0;
        end else if (bus.dataReady) begin
            s       = int'($signed(bus.dataIn));
            lvl     = int'($signed(bus.triggerLevel));
            e_we    = 1'b1;
            e_waddr = m_n % D;
            e_wdata = s;
            if (m_trig < 0 && m_n >= PRE + HOLD && bus.slopeReady) begin
                p = hist[m_n - 1];
                if (bus.triggerRising)
                    hit = (p < lvl) && (s >= lvl) && bus.slopeIsPositive;
                else
                    hit = (p > lvl) && (s <= lvl) && !bus.slopeIsPositive;
                if (hit) begin
                    m_trig  = m_n;
                    m_taddr = m_n % D;
                    e_trig  = 1'b1;
                end
            end
            hist.push_back(s);
            m_n++;
        end
    endtask

    task automatic check_outputs();
        check("writeEnable", int'(bus.writeEnable), int'(e_we));
        check("triggered", int'(bus.triggered), int'(e_trig));
        check("busy", int'(bus.busy), int'(m_armed && !model_done()));
        check("captureDone", int'(bus.captureDone), int'(model_done()));
        check("triggerAddress", int'(bus.triggerAddress), m_taddr);
        if (e_we) begin
            check("writeAddress", int'(bus.writeAddress), e_waddr);
            check("writeData", int'($signed(bus.writeData)), e_wdata);
            mem[bus.writeAddress] = int'($signed(bus.writeData));
        end
        if (model_done() && !m_done_prev) begin
            for (int j = 0; j < D; j++)
                check("window", mem[(m_taddr - PRE + j + D) % D], hist[m_trig - PRE + j]);
        end
        m_done_prev = model_done();
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        bus.dataReady  = 1'b0;
        bus.slopeReady = 1'b0;
        bus.arm        = 1'b0;
        bus.readDone   = 1'b0;
    endtask

    task automatic sample(input int v, input bit slope);
        bus.dataIn          = DW'(v);
        bus.dataReady       = 1'b1;
        bus.slopeReady      = 1'b1;
        bus.slopeIsPositive = slope;
        step();
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_read();
        bus.readDone = 1'b1;
        step();
    endtask

    initial begin
        int walk, last, lvl;
        bus.dataReady       = 1'b0;
        bus.dataIn          = '0;
        bus.slopeReady      = 1'b0;
        bus.slopeIsPositive = 1'b0;
        bus.triggerLevel    = DW'(100);
        bus.triggerRising   = 1'b1;
        bus.arm             = 1'b0;
        bus.readDone        = 1'b0;

        // Reset state and prefill
        do_reset();
        check("rst_writeAddress", int'(bus.writeAddress), 0);
        check("rst_writeData", int'(bus.writeData), 0);
        do_arm();
        sample(10, 1); sample(20, 1); sample(30, 1); sample(40, 1);
        check("t1_busy", int'(bus.busy), 1);
        check("t1_last_addr", int'(bus.writeAddress), 3);

        // Rising trigger on 120, then post window and readDone
        sample(50, 1); sample(80, 1); sample(90, 1); sample(120, 1);
        check("t2_triggered", int'(bus.triggered), 1);
        check("t2_taddr", int'(bus.triggerAddress), 7);
        for (int i = 0; i < 11; i++) sample(130 + i, 1);
        check("t2_done", int'(bus.captureDone), 1);
        sample(5, 1);
        check("t2_no_write", int'(bus.writeEnable), 0);
        do_read();
        check("t2_done_fall", int'(bus.captureDone), 0);

        // Slope mismatch in rising mode, then falling trigger
        do_arm();
        for (int i = 0; i < PRE + 2; i++) sample(0, 1);
        sample(90, 0); sample(120, 0);
        check("t3_no_trig", int'(bus.triggered), 0);
        bus.triggerRising = 1'b0;
        sample(200, 0); sample(50, 0);
        check("t3_fall_trig", int'(bus.triggered), 1);
        for (int i = 0; i < 11; i++) sample(40, 0);
        do_read();

        // Holdoff, wrap, and equality boundary
        bus.triggerRising = 1'b1;
        do_arm();
        sample(10, 1); sample(20, 1); sample(30, 1); sample(90, 1);
        sample(120, 1);
        check("t3_holdoff", int'(bus.triggered), 0);
        for (int i = 0; i < 20; i++) sample(10, 1);
        sample(100, 0); sample(150, 1);
        check("t4_eq_boundary", int'(bus.triggered), 0);
        sample(50, 1); sample(120, 1);
        check("t4_wrap_taddr", int'(bus.triggerAddress), 12);
        for (int i = 0; i < 11; i++) sample(60, 1);
        do_read();

        // arm with dataReady in IDLE
        bus.arm       = 1'b1;
        bus.dataReady = 1'b1;
        bus.dataIn    = DW'(77);
        step();
        check("t5_no_write", int'(bus.writeEnable), 0);
        sample(33, 1);
        check("t5_first_addr", int'(bus.writeAddress), 0);

        // Reset during POST, then restart
        sample(34, 1); sample(35, 1); sample(36, 1);
        sample(0, 1); sample(0, 1); sample(50, 1); sample(150, 1);
        check("t6_trig", int'(bus.triggered), 1);
        sample(160, 1); sample(170, 1);
        bus.dataReady = 1'b1;
        bus.dataIn    = DW'(180);
        do_reset();
        check("t6_we", int'(bus.writeEnable), 0);
        check("t6_busy", int'(bus.busy), 0);
        check("t6_trig_clear", int'(bus.triggered), 0);
        do_arm();
        sample(1, 1);
        check("t6_restart_addr", int'(bus.writeAddress), 0);

        // Randomized traffic
        lvl  = 100;
        last = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) reset = 1'b1;
            bus.arm      = ($urandom_range(0, 99) < 4);
            bus.readDone = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 1) bus.triggerRising = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) < 1) begin
                lvl = int'($urandom_range(0, 400)) - 200;
                bus.triggerLevel = DW'(lvl);
            end
            if ($urandom_range(0, 99) < 70) begin
                walk = lvl + int'($urandom_range(0, 200)) - 100;
                bus.dataReady  = 1'b1;
                bus.slopeReady = ($urandom_range(0, 9) != 0);
                bus.dataIn     = DW'(walk);
                if ($urandom_range(0, 4) != 0)
                    bus.slopeIsPositive = (walk > last);
                else
                    bus.slopeIsPositive = 1'($urandom_range(0, 1));
                last = walk;
            end
            step();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scope_trigger_controller.md
Name: scope_trigger_controller

Overview:
Consumer side of the sample and slope-estimate interface. It takes the raw sample stream plus the slope-sign flag produced by the slope estimator and decides when a trigger event occurs, using level crossing qualified by slope sign. It drives the circular capture buffer's write port so the buffer holds a fixed pre-trigger and post-trigger window. It sits between the ADC/slope-estimator path and the capture RAM that the display logic reads.

Parameters:
DATA_BITS, 12, sample width (signed two's complement).
ADDR_BITS, 10, capture buffer address width; depth D = 2^ADDR_BITS.
PRE_SAMPLES, 256, samples kept before the trigger sample; legal range 1..D-2.
HOLDOFF, 4, accepted samples required in SEARCH before any sample can be a trigger candidate.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
dataReady  input  1  one-cycle strobe; dataIn is valid in this cycle.
dataIn  input  DATA_BITS  signed sample.
slopeReady  input  1  strobe marking slopeIsPositive valid; asserted in the same cycle as dataReady.
slopeIsPositive  input  1  1 = estimated slope > 0.
triggerLevel  input  DATA_BITS  signed trigger threshold; sampled when a candidate is evaluated.
triggerRising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
arm  input  1  one-cycle request to start a capture.
readDone  input  1  one-cycle strobe from the reader; the buffer may be reused.
writeEnable  output  1  buffer write strobe.
writeAddress  output  ADDR_BITS  buffer write address.
writeData  output  DATA_BITS  buffer write data.
triggerAddress  output  ADDR_BITS  buffer address holding the trigger sample.
triggered  output  1  one-cycle pulse, coincident with the trigger sample's write.
captureDone  output  1  level; the window is complete and the buffer is stable.
busy  output  1  high in PREFILL, SEARCH and POST.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal pointer, preCount, holdCount, postCount and prevSample are 0; prevValid is 0. Buffer contents are untouched.
- Reset mid-operation: IDLE on the next edge. writeEnable is 0 from the first cycle after reset is sampled. Any pending triggered or captureDone is cleared.
- Accepted sample: a dataReady cycle while in PREFILL, SEARCH or POST.
  - Next cycle: writeEnable=1, writeData=dataIn, writeAddress=pointer.
  - The pointer then increments modulo D.
  - Write latency is exactly 1 cycle.
  - prevSample<=dataIn and prevValid<=1 on every accepted sample.
- IDLE:
  - arm -> PREFILL; pointer, preCount, holdCount and prevValid are cleared.
  - dataReady is ignored, including when it coincides with arm; capture starts at the next dataReady.
- PREFILL:
  - Each accepted sample increments preCount.
  - After the PRE_SAMPLES-th write -> SEARCH.
  - No sample in PREFILL is a trigger candidate.
- SEARCH:
  - Pointer wraps freely (circular pre-trigger history).
  - holdCount increments per accepted sample, saturating at HOLDOFF.
  - A sample s is a candidate only if slopeReady=1, prevValid=1, and holdCount had already reached HOLDOFF before s.
  - Rising trigger condition: prevSample < L, s >= L, and slopeIsPositive=1.
  - Falling trigger condition: prevSample > L, s <= L, and slopeIsPositive=0.
  - All compares are signed, at full DATA_BITS width.
- On trigger:
  - triggerAddress = address of s.
  - triggered is pulsed in the same cycle as the write of s.
  - postCount is cleared and the state -> POST.
- POST: after D-PRE_SAMPLES-1 further accepted samples are written -> DONE. The window start is triggerAddress-PRE_SAMPLES mod D.
- DONE:
  - captureDone=1 and busy=0; no writes occur.
  - dataReady and arm are ignored.
  - readDone -> IDLE; captureDone falls on the following cycle.
- arm while busy: ignored. readDone outside DONE: ignored.
- triggerAddress holds its value until the next trigger or reset.

Test Plan:
Bench parameters: DATA_BITS=12, ADDR_BITS=4 (D=16), PRE_SAMPLES=4, HOLDOFF=2, rising mode, triggerLevel=100.
1. Reset, arm, then 4 samples (10,20,30,40) -> writes at addresses 0..3, each 1 cycle after its dataReady; busy=1; state SEARCH; triggered=0.
2. After test 1, samples 50,80,90 then 120, all with slopeIsPositive=1 -> triggered on 120 with triggerAddress=7. Then 11 more samples -> captureDone=1. A 12th sample produces no write. readDone -> captureDone=0 one cycle later.
3. Falling mode and holdoff:
   - Crossing 90->120 with slopeIsPositive=0 in rising mode -> no trigger.
   - Switch to triggerRising=0: 200->50 with slopeIsPositive=0 -> triggered.
   - Arm, prefill with 4 samples, then make a crossing on the first SEARCH sample -> ignored (holdoff).
4. Wrap-around: 20 non-crossing SEARCH samples -> writeAddress wraps 15->0. A later trigger reports the correct wrapped triggerAddress. Boundary: prevSample=100, s=150 -> no trigger (100 < 100 is false).
5. Simultaneous events: arm and dataReady in the same cycle in IDLE -> no write; the first write occurs at address 0 on the next dataReady.
6. Reset asserted during POST -> writeEnable=0, busy=0, triggered=0 the next cycle. A subsequent arm restarts the capture at address 0.
